// File: rtl/nonoverlap_gate_ctrl.sv
// nonoverlap_gate_ctrl
//
// Break-before-make gate-drive controller for a CMOS output stage built
// from one pmos pull-up and one nmos pull-down sharing an output node.
// A requested level is turned into separate pmos/nmos gate controls.
// Every level change passes through a programmable dead time with both
// devices off. A disabled mode leaves the node floating.
//
// Parameters
//   DEAD_CYCLES  dead-time length in clock cycles (1 .. 2**CW)
//   CW           dead-time counter width, must hold DEAD_CYCLES-1
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         1 = drive the node, 0 = both devices off (high-Z)
//   in         requested level, 1 = pull-up, 0 = pull-down
//   p_gate     pmos gate, 0 = pmos conducting (registered)
//   n_gate     nmos gate, 1 = nmos conducting (registered)
//   busy       1 while in dead time (registered)
//   drv_state  00 OFF, 01 HIGH, 10 LOW, 11 DEAD
//   sw_cnt     wrapping count of entries into HIGH or LOW
module nonoverlap_gate_ctrl #(
    parameter int DEAD_CYCLES = 3,
    parameter int CW          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic       p_gate,
    output logic       n_gate,
    output logic       busy,
    output logic [1:0] drv_state,
    output logic [7:0] sw_cnt
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10,
        ST_DEAD = 2'b11
    } state_t;

    // The counter holds the number of dead cycles still to go after the
    // current one, so a dead time of N cycles starts from N-1.
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] dead_cnt;
    logic [CW-1:0] dead_cnt_nxt;
    logic          drive_entry;

    // Next-state decision. Disable always wins and drops straight to OFF,
    // which also abandons any dead time in progress. The exit level from
    // DEAD is taken from in at the moment of exit, so a glitch back to the
    // old level still pays the full dead time before returning there.
    always_comb begin
        state_nxt    = state;
        dead_cnt_nxt = dead_cnt;
        if (!en) begin
            state_nxt    = ST_OFF;
            dead_cnt_nxt = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = in ? ST_HIGH : ST_LOW;
                end
                ST_HIGH: begin
                    if (!in) begin
                        state_nxt    = ST_DEAD;
                        dead_cnt_nxt = DEAD_LOAD;
                    end
                end
                ST_LOW: begin
                    if (in) begin
                        state_nxt    = ST_DEAD;
                        dead_cnt_nxt = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt != '0) begin
                        dead_cnt_nxt = dead_cnt - 1'b1;
                    end else begin
                        state_nxt = in ? ST_HIGH : ST_LOW;
                    end
                end
                default: begin
                    state_nxt    = ST_OFF;
                    dead_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A drive entry is any step into HIGH or LOW from a state where both
    // devices were off.
    assign drive_entry = ((state_nxt == ST_HIGH) || (state_nxt == ST_LOW)) &&
                         ((state == ST_OFF) || (state == ST_DEAD));

    // State, counter and outputs are all registered together. Gates are
    // decoded from the next state only: p_gate is low solely in HIGH and
    // n_gate is high solely in LOW, so both devices can never be on at
    // once, and there is no combinational path from en or in to a gate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            dead_cnt <= '0;
            sw_cnt   <= 8'd0;
            p_gate   <= 1'b1;
            n_gate   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_cnt_nxt;
            sw_cnt   <= sw_cnt + {7'd0, drive_entry};
            p_gate   <= (state_nxt != ST_HIGH);
            n_gate   <= (state_nxt == ST_LOW);
            busy     <= (state_nxt == ST_DEAD);
        end
    end

    assign drv_state = state;

endmodule
